// File: rtl/seq_multiplier_param.sv
// seq_multiplier_param
//   Sequential shift-add multiplier, one multiplier bit per clock over WIDTH cycles.
//   Signed mode wraps the unsigned core in sign-magnitude: operand magnitudes are
//   captured at acceptance and the product is negated on completion if needed.
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   start        multiply request, sampled in IDLE or DONE
//   signed_mode  1 = two's complement operands/product, 0 = unsigned (sampled with start)
//   in1          multiplicand (sampled with start)
//   in2          multiplier (sampled with start)
//   out          registered 2*WIDTH-bit product, holds the last result
//   busy         high while calculating
//   done         one-cycle pulse when out is updated
module seq_multiplier_param #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     in1,
    input  logic [WIDTH-1:0]     in2,
    output logic [2*WIDTH-1:0]   out,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             neg_q, neg_d;
    logic [PW-1:0]    out_q, out_d;

    logic [WIDTH-1:0] mag1, mag2;
    logic [PW-1:0]    sum;

    // Magnitudes of the operands; the most-negative value maps to 2^(WIDTH-1),
    // which is still representable as a WIDTH-bit unsigned number.
    always_comb begin
        mag1 = (signed_mode && in1[WIDTH-1]) ? (~in1 + 1'b1) : in1;
        mag2 = (signed_mode && in2[WIDTH-1]) ? (~in2 + 1'b1) : in2;
    end

    // Accumulator value after the current iteration.
    assign sum = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        out_d    = out_q;

        if (state_q == ST_CALC) begin
            acc_d    = sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == LAST_ITER) begin
                // -0 == 0, so negation never produces a spurious nonzero result.
                out_d   = neg_q ? (~sum + 1'b1) : sum;
                state_d = ST_DONE;
            end
        end else begin
            // IDLE and DONE accept a new request identically.
            if (start) begin
                mcand_d  = PW'(mag1);
                mplier_d = mag2;
                acc_d    = '0;
                cnt_d    = '0;
                neg_d    = signed_mode & (in1[WIDTH-1] ^ in2[WIDTH-1]);
                state_d  = ST_CALC;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            out_q    <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            out_q    <= out_d;
        end
    end

    assign out  = out_q;
    assign busy = (state_q == ST_CALC);
    assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_seq_multiplier_param.sv
module tb_seq_multiplier_param;

    logic clk;
    logic rst;

    // WIDTH=4 instance
    logic        s4, sg4;
    logic [3:0]  a4, b4;
    logic [7:0]  o4;
    logic        busy4, done4;

    // WIDTH=8 instance
    logic        s8, sg8;
    logic [7:0]  a8, b8;
    logic [15:0] o8;
    logic        busy8, done8;

    int total;
    int passed;

    seq_multiplier_param #(.WIDTH(4)) u_dut4 (
        .clk         (clk),
        .rst         (rst),
        .start       (s4),
        .signed_mode (sg4),
        .in1         (a4),
        .in2         (b4),
        .out         (o4),
        .busy        (busy4),
        .done        (done4)
    );

    seq_multiplier_param #(.WIDTH(8)) u_dut8 (
        .clk         (clk),
        .rst         (rst),
        .start       (s8),
        .signed_mode (sg8),
        .in1         (a8),
        .in2         (b8),
        .out         (o8),
        .busy        (busy8),
        .done        (done8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and sample 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One WIDTH=8 operation: check busy after acceptance, latency, product, return to idle.
    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic sg, input logic [15:0] exp);
        int n;
        a8 = a; b8 = b; sg8 = sg; s8 = 1'b1;
        step();
        s8 = 1'b0;
        chk({tag, "_busy"}, 32'(busy8), 32'd1);
        n = 0;
        while (!done8 && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'd8);
        chk({tag, "_out"}, 32'(o8), 32'(exp));
        step();
        chk({tag, "_idle"}, 32'(done8), 32'd0);
    endtask

    initial begin
        int n;
        int dcount;
        total = 0; passed = 0;
        rst = 1'b1;
        s4 = 0; sg4 = 0; a4 = 0; b4 = 0;
        s8 = 0; sg8 = 0; a8 = 0; b8 = 0;
        step();
        step();
        rst = 1'b0;
        chk("rst_out8", 32'(o8), 32'd0);
        chk("rst_busy8", 32'(busy8), 32'd0);
        chk("rst_done8", 32'(done8), 32'd0);
        chk("rst_out4", 32'(o4), 32'd0);
        chk("rst_busy4", 32'(busy4), 32'd0);

        // WIDTH=4: 7*10 = 70, busy for 4 cycles, done on the 4th edge.
        a4 = 4'd7; b4 = 4'd10; sg4 = 1'b0; s4 = 1'b1;
        step();
        s4 = 1'b0;
        chk("w4_busy_e0", 32'(busy4), 32'd1);
        for (int i = 1; i < 4; i++) begin
            step();
            chk("w4_busy_mid", 32'(busy4), 32'd1);
            chk("w4_done_mid", 32'(done4), 32'd0);
            chk("w4_out_hold", 32'(o4), 32'd0);
        end
        step();
        chk("w4_done", 32'(done4), 32'd1);
        chk("w4_busy_end", 32'(busy4), 32'd0);
        chk("w4_out", 32'(o4), 32'h46);
        step();
        chk("w4_done_drop", 32'(done4), 32'd0);
        chk("w4_out_hold2", 32'(o4), 32'h46);

        // WIDTH=8 unsigned and signed products.
        run8("u_ff_ff", 8'd255, 8'd255, 1'b0, 16'hFE01);
        run8("u_0_200", 8'd0, 8'd200, 1'b0, 16'h0000);
        run8("u_fd_5", 8'hFD, 8'd5, 1'b0, 16'h04F1);
        run8("s_m3_5", 8'hFD, 8'd5, 1'b1, 16'hFFF1);
        run8("s_m128_m128", 8'h80, 8'h80, 1'b1, 16'h4000);
        run8("s_m128_127", 8'h80, 8'h7F, 1'b1, 16'hC080);
        run8("s_m1_0", 8'hFF, 8'h00, 1'b1, 16'h0000);

        // Start and operand changes during CALC are ignored.
        a8 = 8'd6; b8 = 8'd7; sg8 = 1'b0; s8 = 1'b1;
        step();
        a8 = 8'd9; b8 = 8'd9; sg8 = 1'b1;
        n = 0;
        while (!done8 && n < 20) begin
            chk("ign_busy", 32'(busy8), 32'd1);
            step();
            n++;
        end
        s8 = 1'b0;
        chk("ign_lat", 32'(n), 32'd8);
        chk("ign_out", 32'(o8), 32'd42);
        step();
        chk("ign_idle_busy", 32'(busy8), 32'd0);
        chk("ign_idle_done", 32'(done8), 32'd0);

        // Back-to-back with start held high: done every 9 cycles.
        a8 = 8'd12; b8 = 8'd12; sg8 = 1'b0; s8 = 1'b1;
        step();
        n = 0;
        while (!done8 && n < 20) begin
            step();
            n++;
        end
        chk("b2b_lat0", 32'(n), 32'd8);
        chk("b2b_out0", 32'(o8), 32'd144);
        for (int k = 0; k < 2; k++) begin
            step();
            chk("b2b_rebusy", 32'(busy8), 32'd1);
            chk("b2b_redone", 32'(done8), 32'd0);
            n = 1;
            while (!done8 && n < 20) begin
                step();
                n++;
            end
            chk("b2b_period", 32'(n), 32'd9);
            chk("b2b_out", 32'(o8), 32'd144);
        end
        s8 = 1'b0;
        step();

        // Reset mid-operation discards the partial result.
        a8 = 8'd100; b8 = 8'd100; sg8 = 1'b0; s8 = 1'b1;
        step();
        s8 = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_busy", 32'(busy8), 32'd0);
        chk("mrst_done", 32'(done8), 32'd0);
        chk("mrst_out", 32'(o8), 32'd0);
        dcount = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done8 || busy8) dcount++;
        end
        chk("mrst_quiet", 32'(dcount), 32'd0);
        run8("post_rst_3_4", 8'd3, 8'd4, 1'b0, 16'd12);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/seq_multiplier_param.md
Name: seq_multiplier_param

Overview:
Parametrised sequential shift-add multiplier with a start/busy/done handshake and a runtime signed/unsigned mode.
- Operands are captured on a start request and processed one bit per clock over WIDTH cycles.
- The full-width product is held registered until the next result is produced.
- Serves as the general-width, handshaked multiply unit for the datapath, replacing fixed 4-bit multipliers.

Parameters:
WIDTH, 8, operand width in bits; legal values are WIDTH >= 2; product width is 2*WIDTH.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  reset; synchronous, active-high
start  input  1  request a multiply; sampled only in IDLE or DONE
signed_mode  input  1  1 = operands and product are two's complement; 0 = unsigned; sampled with start
in1  input  WIDTH  multiplicand; sampled with start
in2  input  WIDTH  multiplier; sampled with start
out  output  2*WIDTH  registered product; holds the last result
busy  output  1  high while in CALC
done  output  1  one-cycle pulse when out is updated

Behaviour:
- Reset:
  - rst=1 at a rising edge forces state IDLE and sets out=0, busy=0, done=0; it also clears the internal accumulator, operand registers and counter.
  - Reset takes priority over all other inputs and also applies mid-operation; the partial result is discarded.
- State IDLE:
  - busy=0, done=0.
  - If start=1 at an edge: latch in1, in2 and signed_mode, clear the accumulator, set iteration count=0, then go to CALC.
- State CALC:
  - busy=1.
  - Each edge performs one iteration: if the current multiplier LSB is 1, add the multiplicand (zero-extended to 2*WIDTH) to the accumulator; then shift the multiplicand left by 1, shift the multiplier right by 1, and increment the count.
  - After the WIDTH-th iteration edge: write the final product to out, go to DONE, and assert done=1 with busy=0.
  - start is ignored while in CALC.
  - Changes to in1, in2 or signed_mode after acceptance have no effect.
- State DONE:
  - done=1 for exactly one cycle; out is valid.
  - Next edge: if start=1, accept new operands as in IDLE and go to CALC (back-to-back operation is allowed, with done dropping to 0); otherwise go to IDLE.
- Latency:
  - Start accepted at edge E0, busy=1 from E0; out/done updated at edge E_WIDTH, i.e. done is visible exactly WIDTH cycles after the accepting edge.
  - Throughput is one product per WIDTH+1 cycles.
  - Latency is fixed: there is no early termination on zero operands.
- Signed mode (sign-magnitude around the unsigned core):
  - At acceptance, each operand with MSB=1 is replaced by its two's-complement magnitude, held in WIDTH bits unsigned.
  - The result sign is the XOR of the operand MSBs; if it is 1, out = two's-complement negation of the unsigned product over 2*WIDTH bits.
  - The most-negative operand -2^(WIDTH-1) has magnitude 2^(WIDTH-1), which fits in WIDTH unsigned bits.
  - (-2^(WIDTH-1))^2 = 2^(2*WIDTH-2) fits in the 2*WIDTH signed range; there is no overflow case.
  - A zero product is never negated to a nonzero value, because -0 = 0.
- Unsigned mode: out = in1*in2, exact; the maximum (2^WIDTH-1)^2 fits in 2*WIDTH bits.
- out changes only at reset or on the completing edge; it is stable in IDLE, CALC and DONE otherwise.

Test Plan:
- WIDTH=4, unsigned, in1=7, in2=10, start pulse 1 cycle -> busy high 4 cycles; done pulses on the 4th edge after acceptance; out=8'h46 (70); out holds 70 afterwards.
- WIDTH=8, unsigned, in1=255, in2=255 -> out=16'hFE01 after 8 cycles; in1=0, in2=200 -> out=16'h0000, still with 8-cycle latency.
- WIDTH=8, signed: -3*5 -> out=16'hFFF1; -128*-128 -> out=16'h4000; -128*127 -> out=16'hC080; -1*0 -> out=16'h0000.
- WIDTH=8: accept 6*7, then assert start with 9*9 and change in1/in2 mid-CALC -> the second start is ignored; out=42; busy timing is unchanged.
- WIDTH=8: hold start=1 continuously with 12*12 -> back-to-back results; done pulses every 9 cycles; out=144 each time.
- WIDTH=8: start 100*100, assert rst for 1 cycle at the 4th CALC cycle -> at that edge busy=0, done=0, out=0 and state IDLE; no done pulse follows; a subsequent 3*4 yields out=12.
